stack_queue_ctrl: RTL and testbench
===================================

# stack_queue_ctrl

Pointer and control engine for the synchronous queue/stack built on the dual-port `ram` storage block. It accepts push/pop requests and runs in FIFO (queue) or LIFO (stack) mode. It drives the RAM write port (`we`, write address) and read port (`rde`, read address), and tracks occupancy. It produces a valid strobe aligned with the RAM's one-cycle registered read data. Write data goes from the producer straight to the RAM `dat_i`; read data comes from the RAM `dat_o`. Neither passes through this block.

## Interface
- `adr_width`, default 11: RAM address width.
- `mem_size`, default 2048: RAM depth in words; must be ≤ 2^adr_width.
- `almost_thr`, default 4: margin for the almost flags; used only with `SQC_ALMOST_EN`.

- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `mode_i`, input, 1: 0 = FIFO, 1 = LIFO. Takes effect only while the buffer is empty.
- `push_i`, input, 1: push request for this cycle; write data is on RAM `dat_i` in the same cycle.
- `pop_i`, input, 1: pop request for this cycle.
- `we_o`, output, 1: RAM write enable; combinational.
- `adr_wr_o`, output, adr_width: RAM write address; combinational.
- `rde_o`, output, 1: RAM read enable; combinational.
- `adr_rd_o`, output, adr_width: RAM read address; combinational.
- `valid_o`, output, 1: RAM `dat_o` holds popped data this cycle; registered.
- `count_o`, output, adr_width+1: stored entries, 0..mem_size; registered.
- `full_o`, output, 1: count_o == mem_size; registered.
- `empty_o`, output, 1: count_o == 0; registered.
- `err_o`, output, 1: sticky flag for overflow or underflow; registered.
- `afull_o`, output, 1: almost full; present only with `SQC_ALMOST_EN`.
- `aempty_o`, output, 1: almost empty; present only with `SQC_ALMOST_EN`.

## Operation
- **Registers.** `wr_ptr`, `rd_ptr` (adr_width each), `count`, `mode_q`, `valid`, `err`.
- **Effective mode.** `mode_eff` = `mode_i` when count == 0, otherwise `mode_q`. `mode_q` loads `mode_eff` every cycle, so a mode change while non-empty is ignored.
- **Acceptance.**
  - `push_ok` = push_i & (!full | pop_ok).
  - `pop_ok` = pop_i & !empty.
  - With count == 0, push+pop accepts the push only; there is no read-through.
- **FIFO (`mode_eff`=0).**
  - `adr_wr_o` = wr_ptr; `adr_rd_o` = rd_ptr.
  - `push_ok` increments wr_ptr; `pop_ok` increments rd_ptr.
  - Both pointers wrap from mem_size-1 to 0.
  - When full, push+pop accepts both. The RAM read-before-write returns the old word.
- **LIFO (`mode_eff`=1).**
  - `adr_wr_o` = count[adr_width-1:0] on push-only; `adr_rd_o` = count-1.
  - Push+pop when count > 0 is a swap:
    - `adr_wr_o` = `adr_rd_o` = count-1.
    - The old top is read and the new word overwrites it.
    - Count is unchanged.
  - wr_ptr and rd_ptr are held at 0 in this mode.
- **Enables.** `we_o` = push_ok; `rde_o` = pop_ok. Both are forced to 0 while rst is high.
- **Count.** +1 on push-only, -1 on pop-only, unchanged on both or neither.
- **Flags.**
  - `full_o` and `empty_o` are registered from the next count value.
  - `err_o` sets when push_i & !push_ok, or pop_i & !pop_ok.
  - `err_o` clears only on reset.

## Timing
- **Reset values:** count_o=0, empty_o=1, full_o=0, valid_o=0, err_o=0, wr_ptr=rd_ptr=0, mode_q=0. With `SQC_ALMOST_EN`: afull_o=0, aempty_o=1.
- **Write latency.** A push accepted in cycle N writes the RAM at edge N. The data is poppable from cycle N+1.
- **Read latency.** A pop accepted in cycle N gives valid_o=1 in cycle N+1, aligned with RAM `dat_o`. valid_o lasts one cycle per pop.
- **Back-to-back.** A pop every cycle yields valid_o every cycle.
- **Flag update.** Flags and count reflect the accepted operation from the next cycle.
- **Reset mid-operation.** All registers reset immediately and in-flight valid is dropped. RAM contents are not cleared; they are treated as garbage.

## Configuration
- **`SQC_ALMOST_EN` defined:**
  - afull_o = (count ≥ mem_size-almost_thr).
  - aempty_o = (count ≤ almost_thr).
  - Both are registered from the next count value.
- **Not defined:** the afull_o and aempty_o ports and their logic are absent. All other behaviour is identical.

## Test plan
- **FIFO order.** mem_size=8: push 1..8, then pop 8 times -> full_o=1 after 8th push; valid_o with `dat_o` 1..8 in order; empty_o=1 at end; err_o=0.
- **FIFO wrap and full.** Push 6, pop 4, push 6 -> wr_ptr wraps to 4; count_o=8 and full_o=1. A 9th push sets err_o=1 with we_o=0. Push+pop while full -> count stays 8 and `dat_o` = oldest word.
- **LIFO order and swap.**
  - mode_i=1, push A,B,C, then pop -> `dat_o`=C.
  - Push+pop of D -> `dat_o`=B, count_o=2.
  - Pop -> D; pop -> A.
- **Mode lock.** Set mode_i=1 with count=3 in FIFO -> order stays FIFO. After draining, mode_i=1 takes effect.
- **Underflow/empty corner.** Pop on empty -> rde_o=0, err_o=1, valid_o=0. Push+pop on empty -> push only, count_o=1.
- **Async reset.** Assert rst mid-burst between clock edges -> count_o=0, empty_o=1, valid_o=0, err_o=0 immediately. we_o and rde_o stay 0 while rst is high.

Source files
------------

// File: rtl/stack_queue_ctrl.sv
// Pointer/occupancy engine for a dual-port RAM used as FIFO or LIFO.
// Optional almost-full/almost-empty flags are enabled by defining SQC_ALMOST_EN.
module stack_queue_ctrl #(
  parameter int adr_width  = 11,
  parameter int mem_size   = 2048,
  parameter int almost_thr = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  output logic                 we_o,
  output logic [adr_width-1:0] adr_wr_o,
  output logic                 rde_o,
  output logic [adr_width-1:0] adr_rd_o,
  output logic                 valid_o,
  output logic [adr_width:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 err_o
`ifdef SQC_ALMOST_EN
  ,
  output logic                 afull_o,
  output logic                 aempty_o
`endif
);

  localparam int CW = adr_width + 1;
  localparam logic [adr_width:0]   CNT_MAX  = CW'(mem_size);
  localparam logic [adr_width:0]   CNT_ONE  = CW'(1);
  localparam logic [adr_width-1:0] PTR_LAST = adr_width'(mem_size - 1);
  localparam logic [adr_width-1:0] PTR_ONE  = adr_width'(1);

  logic [adr_width-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [adr_width:0]   count_q, count_d, cnt_m1;
  logic                 mode_q, mode_eff;
  logic                 valid_q, err_q, err_d, full_q, empty_q;
  logic                 push_ok, pop_ok;
  logic [adr_width-1:0] adr_wr, adr_rd;

  always_comb begin
    mode_eff = empty_q ? mode_i : mode_q;
    pop_ok   = pop_i & ~empty_q;
    push_ok  = push_i & (~full_q | pop_ok);
    cnt_m1   = count_q - CNT_ONE;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (mode_eff) begin
      // Stack: top of stack lives at count-1; a push+pop overwrites it in place.
      adr_wr   = (push_ok & pop_ok) ? cnt_m1[adr_width-1:0] : count_q[adr_width-1:0];
      adr_rd   = cnt_m1[adr_width-1:0];
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      adr_wr = wr_ptr_q;
      adr_rd = rd_ptr_q;
      if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = cnt_m1;
      default: count_d = count_q;
    endcase
    err_d = err_q | (push_i & ~push_ok) | (pop_i & ~pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mode_q   <= mode_eff;
      valid_q  <= pop_ok;
      err_q    <= err_d;
      full_q   <= (count_d == CNT_MAX);
      empty_q  <= (count_d == '0);
    end
  end

`ifdef SQC_ALMOST_EN
  logic afull_q, aempty_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= (count_d >= CW'(mem_size - almost_thr));
      aempty_q <= (count_d <= CW'(almost_thr));
    end
  end
  assign afull_o  = afull_q;
  assign aempty_o = aempty_q;
`endif

  // Enables are gated by reset so the RAM is never written or read during reset.
  assign we_o     = push_ok & ~rst;
  assign rde_o    = pop_ok & ~rst;
  assign adr_wr_o = adr_wr;
  assign adr_rd_o = adr_rd;
  assign valid_o  = valid_q;
  assign count_o  = count_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_stack_queue_ctrl.sv
// Scoreboard bench: behavioural RAM plus a queue-based reference of the buffer contents.
module tb_stack_queue_ctrl;
  localparam int AW = 3;
  localparam int MS = 8;

  logic          clk = 1'b0, rst = 1'b1;
  logic          mode_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic          we_o, rde_o, valid_o, full_o, empty_o, err_o;
  logic [AW-1:0] adr_wr_o, adr_rd_o;
  logic [AW:0]   count_o;
  logic [7:0]    din = '0, dout;
  logic [7:0]    mem [MS];

  int total = 0, bad = 0;

  logic [7:0] mq[$];
  logic [7:0] expq[$];
  logic       m_mode = 1'b0, m_err = 1'b0, exp_valid = 1'b0;
  int         m_wp = 0, m_rp = 0;

  stack_queue_ctrl #(.adr_width(AW), .mem_size(MS), .almost_thr(2)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .push_i(push_i), .pop_i(pop_i),
    .we_o(we_o), .adr_wr_o(adr_wr_o), .rde_o(rde_o), .adr_rd_o(adr_rd_o),
    .valid_o(valid_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .err_o(err_o)
`ifdef SQC_ALMOST_EN
    , .afull_o(), .aempty_o()
`endif
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered read; the read samples the old word on a same-address write.
  always @(posedge clk) begin
    if (rde_o) dout <= mem[adr_rd_o];
    if (we_o)  mem[adr_wr_o] <= din;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_regs();
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("full",  32'(full_o),  32'(mq.size() == MS));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("err",   32'(err_o),   32'(m_err));
    chk("valid", 32'(valid_o), 32'(exp_valid));
    if (exp_valid && expq.size() > 0) chk("dat", 32'(dout), 32'(expq.pop_front()));
  endtask

  task automatic step(input logic psh, input logic pp, input logic md, input logic [7:0] d);
    logic meff, pok, sok;
    int   sz;
    @(negedge clk);
    push_i = psh; pop_i = pp; mode_i = md; din = d;
    #1;
    sz   = mq.size();
    meff = (sz == 0) ? md : m_mode;
    pok  = pp && sz > 0;
    sok  = psh && (sz < MS || pok);
    chk("we",  32'(we_o),  32'(sok));
    chk("rde", 32'(rde_o), 32'(pok));
    if (meff) begin
      if (sok) chk("adr_wr_l", 32'(adr_wr_o), 32'(pok ? sz - 1 : sz));
      if (pok) chk("adr_rd_l", 32'(adr_rd_o), 32'(sz - 1));
    end else begin
      if (sok) chk("adr_wr_f", 32'(adr_wr_o), 32'(m_wp));
      if (pok) chk("adr_rd_f", 32'(adr_rd_o), 32'(m_rp));
    end
    @(posedge clk);
    if (pok) begin
      if (meff) expq.push_back(mq.pop_back());
      else      expq.push_back(mq.pop_front());
    end
    if (sok) mq.push_back(d);
    if (meff) begin
      m_wp = 0; m_rp = 0;
    end else begin
      if (sok) m_wp = (m_wp + 1) % MS;
      if (pok) m_rp = (m_rp + 1) % MS;
    end
    m_mode = meff;
    if ((psh && !sok) || (pp && !pok)) m_err = 1'b1;
    exp_valid = pok;
    #1;
    chk_regs();
  endtask

  initial begin
    #12;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full",  32'(full_o),  0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_err",   32'(err_o),   0);
    chk("rst_we",    32'(we_o),    0);
    @(negedge clk); rst = 1'b0;

    // FIFO order
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 8'(i));
    for (int i = 0; i < 8; i++)  step(0, 1, 0, 0);
    // FIFO wrap, overflow, push+pop while full
    for (int i = 0; i < 6; i++)  step(1, 0, 0, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++)  step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++)  step(1, 0, 0, 8'(8'h20 + i));
    step(1, 0, 0, 8'hEE);
    step(1, 1, 0, 8'h30);
    step(1, 1, 0, 8'h31);
    for (int i = 0; i < 8; i++)  step(0, 1, 0, 0);
    // LIFO order and swap
    step(1, 0, 1, 8'hA0); step(1, 0, 1, 8'hB0); step(1, 0, 1, 8'hC0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 8'hD0);
    step(0, 1, 1, 0); step(0, 1, 1, 0);
    // Mode lock: mode_i flips while non-empty, ignored until drained
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    step(1, 0, 1, 8'h50); step(1, 0, 1, 8'h51);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    // Underflow and push+pop on empty
    step(0, 1, 0, 0);
    step(1, 1, 0, 8'h60);
    step(0, 1, 0, 0);
    // Back-to-back pops on a random burst
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

    // Async reset mid-burst with a pop in flight
    step(1, 0, 0, 8'h70); step(1, 0, 0, 8'h71);
    @(negedge clk); push_i = 1'b1; pop_i = 1'b1; din = 8'h72;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("arst_count", 32'(count_o), 0);
    chk("arst_empty", 32'(empty_o), 1);
    chk("arst_valid", 32'(valid_o), 0);
    chk("arst_err",   32'(err_o),   0);
    chk("arst_we",    32'(we_o),    0);
    chk("arst_rde",   32'(rde_o),   0);
    @(posedge clk); #1;
    chk("arst_we2",   32'(we_o),    0);
    chk("arst_rde2",  32'(rde_o),   0);
    @(negedge clk); rst = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    mq.delete(); expq.delete();
    m_mode = 1'b0; m_err = 1'b0; exp_valid = 1'b0; m_wp = 0; m_rp = 0;
    step(1, 0, 0, 8'h80); step(1, 0, 0, 8'h81);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("sb_drained", 32'(expq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
